// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush controller: load-use bubbles, MEM-stage branch squash and
// data-memory wait freezes, with wait timeout and stall/flush performance counters.
module hazard_ctrl #(
    parameter int unsigned WAIT_MAX = 255,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       Id_Rs,
    input  logic [4:0]       Id_Rt,
    input  logic             Id_UseRs,
    input  logic             Id_UseRt,
    input  logic             Ex_MemRd,
    input  logic [4:0]       Ex_Rw,
    input  logic             Mem_Branch,
    input  logic             Mem_MemAcc,
    input  logic             Dmem_Ready,
    output logic             Pc_WrEn,
    output logic             Pc_Sel,
    output logic             IfId_WrEn,
    output logic             IdEx_WrEn,
    output logic             ExMem_WrEn,
    output logic             MemWr_WrEn,
    output logic             IfId_Flush,
    output logic             IdEx_Flush,
    output logic             ExMem_Flush,
    output logic             Bus_Err,
    output logic [CNT_W-1:0] Stall_Cnt,
    output logic [CNT_W-1:0] Flush_Cnt
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [15:0]      wcnt_q, wcnt_d, wcnt_inc;
    logic             bus_err_q, bus_err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             lu, freeze, branch, lu_stall;

    assign lu = Ex_MemRd && (Ex_Rw != 5'd0) &&
                ((Id_UseRs && (Id_Rs == Ex_Rw)) || (Id_UseRt && (Id_Rt == Ex_Rw)));

    // Once the bus has errored the freeze is disabled for good.
    assign freeze   = Mem_MemAcc && !Dmem_Ready && !bus_err_q;
    assign branch   = !freeze && Mem_Branch && !Mem_MemAcc;
    assign lu_stall = !freeze && !branch && lu;

    always_comb begin
        Pc_WrEn     = 1'b1;
        Pc_Sel      = 1'b0;
        IfId_WrEn   = 1'b1;
        IdEx_WrEn   = 1'b1;
        ExMem_WrEn  = 1'b1;
        MemWr_WrEn  = 1'b1;
        IfId_Flush  = 1'b0;
        IdEx_Flush  = 1'b0;
        ExMem_Flush = 1'b0;
        if (freeze) begin
            Pc_WrEn    = 1'b0;
            IfId_WrEn  = 1'b0;
            IdEx_WrEn  = 1'b0;
            ExMem_WrEn = 1'b0;
            MemWr_WrEn = 1'b0;
        end else if (branch) begin
            Pc_Sel      = 1'b1;
            IfId_Flush  = 1'b1;
            IdEx_Flush  = 1'b1;
            ExMem_Flush = 1'b1;
        end else if (lu_stall) begin
            Pc_WrEn    = 1'b0;
            IfId_WrEn  = 1'b0;
            IdEx_Flush = 1'b1;
        end
    end

    // The freeze cycle that enters MEM_WAIT is itself the first wait cycle.
    assign wcnt_inc = (state_q == ST_WAIT) ? wcnt_q + 16'd1 : 16'd1;

    always_comb begin
        state_d   = ST_RUN;
        wcnt_d    = 16'd0;
        bus_err_d = bus_err_q;
        if (freeze) begin
            if (32'(wcnt_inc) >= WAIT_MAX) begin
                bus_err_d = 1'b1;
            end else begin
                state_d = ST_WAIT;
                wcnt_d  = wcnt_inc;
            end
        end
    end

    assign stall_cnt_d = Pc_WrEn ? stall_cnt_q : stall_cnt_q + CNT_W'(1);
    assign flush_cnt_d = branch ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            wcnt_q      <= 16'd0;
            bus_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            bus_err_q   <= bus_err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign Bus_Err   = bus_err_q;
    assign Stall_Cnt = stall_cnt_q;
    assign Flush_Cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: hand-computed control vectors and counter values
// checked with immediate assertions.
module tb_hazard_ctrl;

    logic        clk, rst_n;
    logic [4:0]  Id_Rs, Id_Rt, Ex_Rw;
    logic        Id_UseRs, Id_UseRt, Ex_MemRd, Mem_Branch, Mem_MemAcc, Dmem_Ready;
    logic        Pc_WrEn, Pc_Sel, IfId_WrEn, IdEx_WrEn, ExMem_WrEn, MemWr_WrEn;
    logic        IfId_Flush, IdEx_Flush, ExMem_Flush, Bus_Err;
    logic [31:0] Stall_Cnt, Flush_Cnt;

    int passed = 0;
    int total  = 0;

    // {Pc_WrEn, Pc_Sel, IfId, IdEx, ExMem, MemWr WrEn, IfId, IdEx, ExMem Flush}
    localparam logic [8:0] C_DEF    = 9'b1_0_1111_000;
    localparam logic [8:0] C_LU     = 9'b0_0_0111_010;
    localparam logic [8:0] C_BRANCH = 9'b1_1_1111_111;
    localparam logic [8:0] C_FREEZE = 9'b0_0_0000_000;

    hazard_ctrl #(.WAIT_MAX(4), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .Id_Rs(Id_Rs), .Id_Rt(Id_Rt), .Id_UseRs(Id_UseRs), .Id_UseRt(Id_UseRt),
        .Ex_MemRd(Ex_MemRd), .Ex_Rw(Ex_Rw), .Mem_Branch(Mem_Branch),
        .Mem_MemAcc(Mem_MemAcc), .Dmem_Ready(Dmem_Ready),
        .Pc_WrEn(Pc_WrEn), .Pc_Sel(Pc_Sel), .IfId_WrEn(IfId_WrEn), .IdEx_WrEn(IdEx_WrEn),
        .ExMem_WrEn(ExMem_WrEn), .MemWr_WrEn(MemWr_WrEn), .IfId_Flush(IfId_Flush),
        .IdEx_Flush(IdEx_Flush), .ExMem_Flush(ExMem_Flush), .Bus_Err(Bus_Err),
        .Stall_Cnt(Stall_Cnt), .Flush_Cnt(Flush_Cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    task automatic chk_ctrl(input string tag, input logic [8:0] exp);
        chk(tag, {23'd0, Pc_WrEn, Pc_Sel, IfId_WrEn, IdEx_WrEn, ExMem_WrEn, MemWr_WrEn,
                  IfId_Flush, IdEx_Flush, ExMem_Flush}, {23'd0, exp});
    endtask

    task automatic idle();
        Id_Rs = 5'd0; Id_Rt = 5'd0; Ex_Rw = 5'd0;
        Id_UseRs = 1'b0; Id_UseRt = 1'b0; Ex_MemRd = 1'b0;
        Mem_Branch = 1'b0; Mem_MemAcc = 1'b0; Dmem_Ready = 1'b1;
    endtask

    // Drive phase starts after a falling edge; registered values are read 1 after rising.
    task automatic to_drive();
        @(negedge clk);
    endtask

    task automatic to_sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        #12;
        chk_ctrl("reset_ctrl", C_DEF);
        chk("reset_stall", Stall_Cnt, 0);
        chk("reset_flush", Flush_Cnt, 0);
        chk("reset_buserr", {31'd0, Bus_Err}, 0);
        chk("reset_state", {31'd0, dut.state_q}, 0);
        to_drive();
        rst_n = 1'b1;

        // Load-use on Rs: one bubble.
        to_drive();
        Ex_MemRd = 1'b1; Ex_Rw = 5'd3; Id_Rs = 5'd3; Id_UseRs = 1'b1;
        #1 chk_ctrl("lu_rs_ctrl", C_LU);
        to_sample();
        chk("lu_rs_stall", Stall_Cnt, 1);
        to_drive();
        idle();
        #1 chk_ctrl("lu_after_ctrl", C_DEF);

        // $0 destination never stalls.
        to_drive();
        Ex_MemRd = 1'b1; Ex_Rw = 5'd0; Id_Rs = 5'd0; Id_UseRs = 1'b1;
        #1 chk_ctrl("zero_reg_ctrl", C_DEF);
        to_sample();
        chk("zero_reg_stall", Stall_Cnt, 1);

        // Unused Rt with a match does not stall; used Rt does.
        to_drive();
        idle();
        Ex_MemRd = 1'b1; Ex_Rw = 5'd5; Id_Rt = 5'd5; Id_UseRt = 1'b0;
        #1 chk_ctrl("unused_rt_ctrl", C_DEF);
        to_drive();
        Id_UseRt = 1'b1;
        #1 chk_ctrl("lu_rt_ctrl", C_LU);
        to_sample();
        chk("lu_rt_stall", Stall_Cnt, 2);

        // Branch overrides a simultaneous load-use.
        to_drive();
        Mem_Branch = 1'b1;
        #1 chk_ctrl("branch_ctrl", C_BRANCH);
        to_sample();
        chk("branch_flush_cnt", Flush_Cnt, 1);
        chk("branch_stall_cnt", Stall_Cnt, 2);

        // Branch together with a memory access is ignored.
        to_drive();
        idle();
        Mem_Branch = 1'b1; Mem_MemAcc = 1'b1; Dmem_Ready = 1'b1;
        #1 chk_ctrl("branch_memacc_ctrl", C_DEF);
        to_sample();
        chk("branch_memacc_flush", Flush_Cnt, 1);

        // Three wait cycles, then release with a load-use pending.
        to_drive();
        idle();
        Mem_MemAcc = 1'b1; Dmem_Ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk_ctrl("wait_ctrl", C_FREEZE);
            to_sample();
            chk("wait_state", {31'd0, dut.state_q}, 1);
            to_drive();
        end
        chk("wait_stall", Stall_Cnt, 5);
        Dmem_Ready = 1'b1;
        Ex_MemRd = 1'b1; Ex_Rw = 5'd7; Id_Rs = 5'd7; Id_UseRs = 1'b1;
        #1 chk_ctrl("release_lu_ctrl", C_LU);
        to_sample();
        chk("release_state", {31'd0, dut.state_q}, 0);
        chk("release_stall", Stall_Cnt, 6);
        chk("release_buserr", {31'd0, Bus_Err}, 0);

        // Timeout after four wait cycles.
        to_drive();
        idle();
        Mem_MemAcc = 1'b1; Dmem_Ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1 chk_ctrl("timeout_freeze_ctrl", C_FREEZE);
            chk("timeout_buserr_low", {31'd0, Bus_Err}, 0);
            to_sample();
            to_drive();
        end
        chk("timeout_buserr", {31'd0, Bus_Err}, 1);
        chk("timeout_state", {31'd0, dut.state_q}, 0);
        chk("timeout_stall", Stall_Cnt, 10);
        #1 chk_ctrl("post_err_ctrl", C_DEF);
        to_sample();
        chk("post_err_sticky", {31'd0, Bus_Err}, 1);
        chk("post_err_stall", Stall_Cnt, 10);

        // Reset mid-wait.
        to_drive();
        idle();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        chk("rst2_buserr", {31'd0, Bus_Err}, 0);
        to_drive();
        Mem_MemAcc = 1'b1; Dmem_Ready = 1'b0;
        to_sample();
        to_sample();
        chk("midwait_state", {31'd0, dut.state_q}, 1);
        chk("midwait_stall", Stall_Cnt, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_state", {31'd0, dut.state_q}, 0);
        chk("abort_stall", Stall_Cnt, 0);
        chk("abort_flush", Flush_Cnt, 0);
        idle();
        #1 chk_ctrl("abort_ctrl", C_DEF);
        to_drive();
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline stall/flush controller for the 5-stage CPU. It sequences the IF/ID/EX/MEM/WB pipeline registers by holding or bubbling them on three events: load-use data hazards, taken branches/jumps resolved in MEM, and multi-cycle data-memory accesses. It sits beside the forwarding logic and drives the write-enable/flush pins of every pipeline register plus the PC select. It also keeps wait-timeout and performance counters.

## Interface
- WAIT_MAX, 255: max consecutive MEM_WAIT cycles before a bus error; range 1..65535.
- CNT_W, 32: width of performance counters.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- Id_Rs, Id_Rt  in  5 each  source registers of the instruction in ID.
- Id_UseRs, Id_UseRt  in  1 each  ID instruction reads Rs / Rt in EX. Sw store data on Rt counts as a use.
- Ex_MemRd  in  1  instruction in EX is a load (lw/lb).
- Ex_Rw  in  5  destination register of the EX instruction.
- Mem_Branch  in  1  taken branch/jump resolved in MEM.
- Mem_MemAcc  in  1  MEM instruction accesses data memory (load or store).
- Dmem_Ready  in  1  data memory completes the access this cycle.
- Pc_WrEn  out  1  PC register load enable.
- Pc_Sel  out  1  0 = PC+4, 1 = branch target from MEM.
- IfId_WrEn, IdEx_WrEn, ExMem_WrEn, MemWr_WrEn  out  1 each  pipeline register hold (0 = hold).
- IfId_Flush, IdEx_Flush, ExMem_Flush  out  1 each  load a bubble (all control zero) on this edge.
- Bus_Err  out  1  sticky; a memory access exceeded WAIT_MAX wait cycles.
- Stall_Cnt, Flush_Cnt  out  CNT_W each  count of stall cycles and of flush events.

## Operation
- State register: RUN, MEM_WAIT. Wait counter Wcnt is 16 bits. The control outputs are combinational from state and inputs. Bus_Err and the counters are registered.
- Load-use hazard: LU = Ex_MemRd && Ex_Rw!=0 && ((Id_UseRs && Id_Rs==Ex_Rw) || (Id_UseRt && Id_Rt==Ex_Rw)).
- Defaults (no event): every WrEn = 1, every Flush = 0, Pc_Sel = 0.
- Priority per cycle, highest first:
  1. Memory freeze: Mem_MemAcc && !Dmem_Ready && !Bus_Err. All four register WrEn and Pc_WrEn are 0. Flushes are 0. Next state is MEM_WAIT.
  2. Branch: Mem_Branch && !Mem_MemAcc. Pc_Sel = 1 and Pc_WrEn = 1. IfId_Flush, IdEx_Flush and ExMem_Flush are 1. LU is ignored.
  3. Load-use: LU. Pc_WrEn = 0 and IfId_WrEn = 0. IdEx_Flush = 1. The other registers advance.
- Mem_Branch together with Mem_MemAcc is illegal. MemAcc wins and the branch is ignored.
- MEM_WAIT:
  - While !Dmem_Ready, the freeze continues and Wcnt increments.
  - When Dmem_Ready = 1, that cycle is evaluated exactly as in RUN (rules 2 and 3 apply) and the next state is RUN.
  - Wcnt is cleared on entry to RUN.
- Timeout: when Wcnt reaches WAIT_MAX in MEM_WAIT, Bus_Err is set and the next state is RUN. While Bus_Err = 1, rule 1 is disabled: the pipeline proceeds with undefined load data. Only reset clears Bus_Err.
- Stall_Cnt increments on every cycle where Pc_WrEn = 0.
- Flush_Cnt increments on every cycle where the branch rule fires.
- Both counters wrap modulo 2^CNT_W.

## Timing
- Reset, asynchronous: state = RUN, Wcnt = 0, Bus_Err = 0, Stall_Cnt = Flush_Cnt = 0. The control outputs then take their default values (all WrEn 1, Flush 0, Pc_Sel 0) whenever the hazard inputs are idle.
- Control outputs have zero latency: each acts on the same rising edge on which its input condition is true.
- A load-use hazard costs exactly 1 bubble. On the next cycle the load is in MEM and LU is false, so forwarding supplies the data.
- A taken branch costs 3 squashed instructions, and the target is fetched in the following cycle.
- A memory access with N wait cycles (Dmem_Ready low for N cycles) causes N frozen cycles and N Stall_Cnt increments.
- When MEM_WAIT releases, a simultaneous LU stalls in that same release cycle. There is no extra gap.
- A reset asserted mid-wait aborts MEM_WAIT immediately. Counters are lost.

## Test plan
- **Load-use:** lw $3 in EX, ID add uses Rs = 3 (Id_UseRs = 1). Required: Pc_WrEn = 0, IfId_WrEn = 0, IdEx_Flush = 1 for one cycle; Stall_Cnt = 1; next cycle is defaults.
- **$0 and unused sources:**
  - Ex_Rw = 0 with Id_Rs = 0 → no stall.
  - Id_UseRt = 0 with an Rt match → no stall.
- **Branch:** Mem_Branch = 1 with LU also true. Required: Pc_Sel = 1, Pc_WrEn = 1, all three Flush = 1, no stall; Flush_Cnt = 1.
- **Memory wait:**
  - Mem_MemAcc = 1 with Dmem_Ready low for 3 cycles → all WrEn = 0 for 3 cycles, state MEM_WAIT, Stall_Cnt = 3.
  - On the ready cycle with LU = 1 → the load-use pattern is driven and the state returns to RUN.
- **Timeout:** WAIT_MAX = 4 and Dmem_Ready held low. Required: Bus_Err rises after 4 wait cycles and stays set; later accesses with Dmem_Ready = 0 do not freeze.
- **Reset mid-wait:** after 2 wait cycles, pull rst_n low asynchronously between edges. Required: state RUN, counters 0, outputs at defaults with idle inputs.
